marquee_ctrl: RTL and testbench

MARQUEE_CTRL -- requirements
Module: marquee_ctrl

---
 rtl/marquee_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_marquee_ctrl.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/marquee_ctrl.sv
// marquee_ctrl: button-driven controller for an external 8-bit right-shift register.
// The controller parallel-loads one of four patterns into the register, then clocks it
// once every TICK_DIV cycles. In ring mode the bit shifted in is the register's own
// bit 0, so the pattern rotates. In fill mode a toggling fill bit is shifted in
// instead, so the register fills with ones and then empties to zeros.
//
//   state | meaning
//   ------+----------------------------------------------------------
//   IDLE  | waiting for the first load request, no shifting
//   LOAD  | one-cycle parallel load of the selected pattern
//   RUN   | prescaler counting, one shift per TICK_DIV cycles
//   PAUSE | prescaler and step count frozen until the next pause press
module marquee_ctrl #(
    parameter int TICK_DIV = 50000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_load,
    input  logic       btn_pause,
    input  logic       btn_mode,
    input  logic [1:0] pat_sel,
    input  logic [7:0] q_fb,
    output logic       sh_en,
    output logic       SL,
    output logic       ser_in,
    output logic [7:0] p_data,
    output logic       mode,
    output logic [1:0] state,
    output logic [2:0] step_cnt
);

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        LOAD  = 2'b01,
        RUN   = 2'b10,
        PAUSE = 2'b11
    } state_t;

    state_t        cur_state;
    state_t        next_state;
    logic          load_prev;
    logic          pause_prev;
    logic          mode_prev;
    logic          load_edge;
    logic          pause_edge;
    logic          mode_edge;
    logic          pause_take;
    logic          run_adv;
    logic          shift_tick;
    logic [PW-1:0] presc;
    logic          fill_bit;
    logic [7:0]    p_last;
    logic [7:0]    pattern;
    logic          q_fb_unused;

    // Only bit 0 of the register feedback is needed (ring mode); the rest is unused.
    assign q_fb_unused = ^q_fb[7:1];

    assign load_edge  = btn_load  & ~load_prev;
    assign pause_edge = btn_pause & ~pause_prev;
    assign mode_edge  = btn_mode  & ~mode_prev;

    // A load press beats a simultaneous pause press, which is then simply dropped.
    // A pause press taken in RUN freezes the prescaler on that very cycle, so the
    // prescaler value seen at the press is the value resumed from (and a pending
    // terminal-count shift is deferred until after the resume).
    assign pause_take = pause_edge & ~load_edge;
    assign run_adv    = (cur_state == RUN) & ~pause_take;
    assign shift_tick = run_adv & (presc == PRESC_LAST);

    assign ser_in = mode ? fill_bit : q_fb[0];
    assign state  = cur_state;

    // Pattern table selected by pat_sel.
    always_comb begin
        pattern = 8'h01;
        case (pat_sel)
            2'b00:   pattern = 8'h01;
            2'b01:   pattern = 8'h81;
            2'b10:   pattern = 8'hAA;
            default: pattern = 8'h0F;
        endcase
    end

    // Registered copies of the button levels for rising-edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            load_prev  <= 1'b0;
            pause_prev <= 1'b0;
            mode_prev  <= 1'b0;
        end else begin
            load_prev  <= btn_load;
            pause_prev <= btn_pause;
            mode_prev  <= btn_mode;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_state <= IDLE;
        end else begin
            cur_state <= next_state;
        end
    end

    // FSM next-state logic.
    always_comb begin
        next_state = cur_state;
        case (cur_state)
            IDLE: begin
                if (load_edge) next_state = LOAD;
            end
            LOAD: begin
                next_state = RUN;
            end
            RUN: begin
                if (load_edge)       next_state = LOAD;
                else if (pause_edge) next_state = PAUSE;
            end
            PAUSE: begin
                if (load_edge)       next_state = LOAD;
                else if (pause_edge) next_state = RUN;
            end
            default: next_state = IDLE;
        endcase
    end

    // FSM outputs: load strobe in LOAD, shift strobe at terminal count in RUN.
    always_comb begin
        sh_en  = 1'b0;
        SL     = 1'b0;
        p_data = p_last;
        case (cur_state)
            LOAD: begin
                sh_en  = 1'b1;
                p_data = pattern;
            end
            RUN: begin
                if (shift_tick) begin
                    sh_en = 1'b1;
                    SL    = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Shift-rate prescaler: cleared by LOAD, counts only while advancing in RUN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc <= '0;
        end else if (cur_state == LOAD) begin
            presc <= '0;
        end else if (run_adv) begin
            presc <= (presc == PRESC_LAST) ? '0 : presc + PW'(1);
        end
    end

    // Step counter and fill bit; the fill bit flips each time a full 8-step pass ends.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step_cnt <= 3'd0;
            fill_bit <= 1'b1;
        end else if (cur_state == LOAD) begin
            step_cnt <= 3'd0;
            fill_bit <= 1'b1;
        end else if (shift_tick) begin
            step_cnt <= step_cnt + 3'd1;
            if (step_cnt == 3'd7) fill_bit <= ~fill_bit;
        end
    end

    // Remember the last loaded pattern so p_data holds it between loads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_last <= 8'h00;
        end else if (cur_state == LOAD) begin
            p_last <= pattern;
        end
    end

    // Ring/fill mode toggles on any mode press, regardless of state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode <= 1'b0;
        end else if (mode_edge) begin
            mode <= ~mode;
        end
    end

endmodule

// File: tb/tb_marquee_ctrl.sv
// tb_marquee_ctrl: directed scenarios plus randomized button activity for marquee_ctrl,
// checked every cycle against a behavioural model of the controller and of the
// shift register it drives.
module tb_marquee_ctrl;

    localparam int TICK = 4;
    localparam int M_IDLE  = 0;
    localparam int M_LOAD  = 1;
    localparam int M_RUN   = 2;
    localparam int M_PAUSE = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_load = 1'b0;
    logic       btn_pause = 1'b0;
    logic       btn_mode = 1'b0;
    logic [1:0] pat_sel = 2'b00;
    logic [7:0] q_fb = 8'h00;
    logic       sh_en;
    logic       SL;
    logic       ser_in;
    logic [7:0] p_data;
    logic       mode;
    logic [1:0] state;
    logic [2:0] step_cnt;

    int errors = 0;
    int checks = 0;

    // Model state.
    int         m_state;
    int         m_presc;
    int         m_step;
    int         m_shifts = 0;
    logic       m_fill;
    logic       m_mode;
    logic [7:0] m_plast;
    logic [7:0] m_q = 8'h00;
    logic       m_pl;
    logic       m_pp;
    logic       m_pm;

    marquee_ctrl #(.TICK_DIV(TICK)) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_load (btn_load),
        .btn_pause(btn_pause),
        .btn_mode (btn_mode),
        .pat_sel  (pat_sel),
        .q_fb     (q_fb),
        .sh_en    (sh_en),
        .SL       (SL),
        .ser_in   (ser_in),
        .p_data   (p_data),
        .mode     (mode),
        .state    (state),
        .step_cnt (step_cnt)
    );

    always #5 clk = ~clk;

    // The physical 8-bit shift register controlled by the DUT (shifts right, ser_in at MSB).
    always @(posedge clk) begin
        if (sh_en) q_fb <= SL ? {ser_in, q_fb[7:1]} : p_data;
    end

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] pattern_of(input logic [1:0] s);
        case (s)
            2'b00:   return 8'h01;
            2'b01:   return 8'h81;
            2'b10:   return 8'hAA;
            default: return 8'h0F;
        endcase
    endfunction

    task automatic model_reset();
        m_state = M_IDLE;
        m_presc = 0;
        m_step  = 0;
        m_fill  = 1'b1;
        m_mode  = 1'b0;
        m_plast = 8'h00;
        m_pl    = 1'b0;
        m_pp    = 1'b0;
        m_pm    = 1'b0;
    endtask

    // One clock: check outputs at the falling edge, advance the model, return just after the rising edge.
    task automatic tick();
        logic le, pe, me, pe_eff, shift, e_sh, e_sl, e_ser;
        logic [7:0] e_p;
        @(negedge clk);
        le = btn_load  && !m_pl && !rst;
        pe = btn_pause && !m_pp && !rst;
        me = btn_mode  && !m_pm && !rst;
        pe_eff = pe && !le;
        shift  = (m_state == M_RUN) && !pe_eff && (m_presc == TICK - 1);
        e_sh   = (m_state == M_LOAD) || shift;
        e_sl   = shift;
        e_p    = (m_state == M_LOAD) ? pattern_of(pat_sel) : m_plast;
        e_ser  = m_mode ? m_fill : m_q[0];
        chk_eq("state", state, m_state);
        chk_eq("sh_en", sh_en, e_sh);
        chk_eq("SL", SL, e_sl);
        chk_eq("p_data", p_data, e_p);
        chk_eq("mode", mode, m_mode);
        chk_eq("step_cnt", step_cnt, m_step);
        chk_eq("ser_in", ser_in, e_ser);
        chk_eq("q_fb", q_fb, m_q);
        if (rst) begin
            model_reset();
        end else begin
            if (e_sh) m_q = e_sl ? {e_ser, m_q[7:1]} : e_p;
            if (shift) m_shifts++;
            if (m_state == M_LOAD) begin
                m_presc = 0;
                m_step  = 0;
                m_fill  = 1'b1;
                m_plast = e_p;
            end else if (m_state == M_RUN && !pe_eff) begin
                if (shift) begin
                    m_presc = 0;
                    m_step  = (m_step + 1) % 8;
                    if (m_step == 0) m_fill = !m_fill;
                end else begin
                    m_presc++;
                end
            end
            if (me) m_mode = !m_mode;
            if (m_state == M_LOAD)                 m_state = M_RUN;
            else if (le)                           m_state = M_LOAD;
            else if (pe && m_state == M_RUN)       m_state = M_PAUSE;
            else if (pe && m_state == M_PAUSE)     m_state = M_RUN;
            m_pl = btn_load;
            m_pp = btn_pause;
            m_pm = btn_mode;
        end
        @(posedge clk);
        #1;
    endtask

    // Hold the requested buttons high for one cycle, then release them.
    task automatic press(input logic l, input logic p, input logic m);
        btn_load  = l;
        btn_pause = p;
        btn_mode  = m;
        tick();
        btn_load  = 1'b0;
        btn_pause = 1'b0;
        btn_mode  = 1'b0;
    endtask

    task automatic run_shifts(input int n);
        int target;
        int budget;
        target = m_shifts + n;
        budget = n * TICK * 2 + 20;
        while (m_shifts < target && budget > 0) begin
            tick();
            budget--;
        end
        if (m_shifts < target) chk_eq("shift_budget", 32'(m_shifts), 32'(target));
    endtask

    // Assert reset between clock edges and check that outputs clear without waiting for a clock.
    task automatic async_reset_mid();
        #2 rst = 1'b1;
        #1;
        chk_eq("async_state", state, 0);
        chk_eq("async_sh_en", sh_en, 0);
        chk_eq("async_SL", SL, 0);
        chk_eq("async_p_data", p_data, 8'h00);
        chk_eq("async_mode", mode, 0);
        chk_eq("async_step", step_cnt, 0);
        model_reset();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int budget;
        model_reset();
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Scenario 1: load pattern 0x81.
        pat_sel = 2'b01;
        press(1'b1, 1'b0, 1'b0);
        chk_eq("s1_load_state", state, 1);
        chk_eq("s1_load_sh_en", sh_en, 1);
        chk_eq("s1_load_SL", SL, 0);
        chk_eq("s1_load_p_data", p_data, 8'h81);
        tick();
        chk_eq("s1_run_state", state, 2);
        chk_eq("s1_loaded_q", q_fb, 8'h81);

        // Scenario 2: ring rotation, 10 shifts, step count wraps.
        run_shifts(1);
        chk_eq("s2_q_after1", q_fb, 8'hC0);
        run_shifts(1);
        chk_eq("s2_q_after2", q_fb, 8'h60);
        run_shifts(6);
        chk_eq("s2_step_wrap", step_cnt, 0);
        run_shifts(2);
        chk_eq("s2_step_after10", step_cnt, 2);

        // Scenario 3: pause at prescaler 2, hold, resume.
        budget = 20;
        while (!(m_state == M_RUN && m_presc == 2) && budget > 0) begin
            tick();
            budget--;
        end
        press(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) begin
            chk_eq("s3_paused_sh_en", sh_en, 0);
            chk_eq("s3_paused_state", state, 3);
            tick();
        end
        press(1'b0, 1'b1, 1'b0);
        n = 1;
        while (!sh_en && n < 10) begin
            tick();
            n++;
        end
        chk_eq("s3_resume_gap", 32'(n), 2);

        // Scenario 4: fill mode, load 0x01 together with the mode press.
        pat_sel = 2'b00;
        press(1'b1, 1'b0, 1'b1);
        run_shifts(8);
        chk_eq("s4_fill_ones", q_fb, 8'hFF);
        run_shifts(8);
        chk_eq("s4_fill_zeros", q_fb, 8'h00);
        press(1'b0, 1'b0, 1'b1);

        // Scenario 5: load and pause in the same cycle during RUN.
        run_shifts(1);
        tick();
        pat_sel = 2'b10;
        press(1'b1, 1'b1, 1'b0);
        chk_eq("s5_load_state", state, 1);
        tick();
        chk_eq("s5_run_state", state, 2);
        tick();
        chk_eq("s5_still_run", state, 2);

        // Scenario 6: async reset mid-RUN, load button held through reset.
        run_shifts(1);
        tick();
        async_reset_mid();
        btn_load = 1'b1;
        pat_sel  = 2'b11;
        for (int i = 0; i < 3; i++) tick();
        rst = 1'b0;
        tick();
        chk_eq("s6_held_btn_load", state, 1);
        btn_load = 1'b0;
        tick();

        // Randomized button activity with occasional asynchronous resets.
        for (int i = 0; i < 1500; i++) begin
            int r;
            r = $urandom_range(0, 299);
            pat_sel = 2'($urandom);
            if (r < 5)              btn_load  = ~btn_load;
            if (r >= 3 && r < 20)   btn_pause = ~btn_pause;
            if (r >= 18 && r < 28)  btn_mode  = ~btn_mode;
            if (r == 299) begin
                async_reset_mid();
                tick();
                rst = 1'b0;
            end
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
